// File: rtl/mem_arbiter_pkg.sv
// ============================================================================
// Module  : mem_arbiter_pkg
// Purpose : Shared types for the work-RAM arbiter. Holds the arbiter state
//           enum, the read-owner tag enum and the DMA length field width.
// Ports   : none (package)
// Config  : none
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package mem_arbiter_pkg;

  // Width of the dma_len field (burst length minus one).
  localparam int DMA_LEN_W = 4;

  // Arbiter FSM: waiting for a request, or working through a burst.
  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state;

  // Tag travelling alongside each read to steer the returned RAM data.
  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_DMA = 1'b1
  } arb_owner;

endpackage : mem_arbiter_pkg

`default_nettype wire

// File: rtl/mem_arbiter_burst.sv
// ============================================================================
// Module  : mem_arbiter_burst
// Purpose : DMA burst sequencer. Holds the next-beat address and the
//           remaining-beat count, increments/decrements them on each issued
//           beat and flags the final beat. Built only when
//           MEM_ARBITER_BURST_EN is defined.
// Ports   : clk, reset_n      clock / async active-low reset
//           i_load            burst start (controls are sampled this cycle)
//           i_addr, i_len     start address and length-minus-one
//           i_beat            a beat is issued to RAM this cycle
//           o_addr            address of the beat in this cycle
//           o_last            the beat in this cycle is the final one
// Config  : MEM_ARBITER_BURST_EN
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

`ifdef MEM_ARBITER_BURST_EN
module mem_arbiter_burst
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_load,
  input  logic [ADDR_W-1:0]    i_addr,
  input  logic [DMA_LEN_W-1:0] i_len,
  input  logic                 i_beat,
  output logic [ADDR_W-1:0]    o_addr,
  output logic                 o_last
);

  logic [ADDR_W-1:0]    r_addr;
  logic [DMA_LEN_W-1:0] r_cnt;
  logic [ADDR_W-1:0]    w_base_addr;
  logic [DMA_LEN_W-1:0] w_base_cnt;

  // In the start cycle the first beat uses the request controls directly,
  // so a beat can issue in the same cycle the burst is accepted.
  assign w_base_addr = i_load ? i_addr : r_addr;
  assign w_base_cnt  = i_load ? i_len  : r_cnt;

  assign o_addr = w_base_addr;
  assign o_last = (w_base_cnt == '0);

  // The address wraps naturally at 2^ADDR_W. After the last beat the
  // registers hold stale values that the next load overwrites.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr <= '0;
      r_cnt  <= '0;
    end else if (i_beat) begin
      r_addr <= w_base_addr + ADDR_W'(1);
      r_cnt  <= w_base_cnt - DMA_LEN_W'(1);
    end else if (i_load) begin
      r_addr <= w_base_addr;
      r_cnt  <= w_base_cnt;
    end
  end

endmodule : mem_arbiter_burst
`endif

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module  : mem_arbiter
// Purpose : Work-RAM arbiter between the CPU port (absolute priority on its
//           clk_en access cycles) and a DMA requester served in every free
//           cycle via req/ack, with optional auto-incrementing bursts.
//           Read data (one-cycle RAM latency) is routed back to the owner.
// Ports   : clk, reset_n                       clock / async active-low reset
//           clk_en, cpu_read_en, cpu_write_en  CPU access qualifiers
//           cpu_addr, cpu_write_data           CPU address / write data
//           cpu_read_data                      last CPU read result (held)
//           dma_req, dma_write, dma_addr,
//           dma_len, dma_write_data            DMA request controls
//           dma_ack, dma_done                  per-beat / final-beat pulses
//           dma_read_data, dma_read_valid      DMA read return
//           ram_addr, ram_we, ram_wdata        RAM controls (combinational)
//           ram_rdata                          RAM read data (1-cycle latency)
// Config  : MEM_ARBITER_BURST_EN - when defined, dma_len selects a burst of
//           dma_len+1 beats; otherwise every request is a single beat.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 clk_en,
  input  logic                 cpu_read_en,
  input  logic                 cpu_write_en,
  input  logic [ADDR_W-1:0]    cpu_addr,
  input  logic [DATA_W-1:0]    cpu_write_data,
  output logic [DATA_W-1:0]    cpu_read_data,
  input  logic                 dma_req,
  input  logic                 dma_write,
  input  logic [ADDR_W-1:0]    dma_addr,
  input  logic [DMA_LEN_W-1:0] dma_len,
  input  logic [DATA_W-1:0]    dma_write_data,
  output logic                 dma_ack,
  output logic                 dma_done,
  output logic [DATA_W-1:0]    dma_read_data,
  output logic                 dma_read_valid,
  output logic [ADDR_W-1:0]    ram_addr,
  output logic                 ram_we,
  output logic [DATA_W-1:0]    ram_wdata,
  input  logic [DATA_W-1:0]    ram_rdata
);

  arb_state          r_state;
  arb_state          w_state_nxt;
  logic              r_dir;
  logic              w_cpu_slot;
  logic              w_cpu_rd;
  logic              w_load;
  logic              w_beat;
  logic              w_last;
  logic              w_dir;
  logic              w_dma_rd;
  logic [ADDR_W-1:0] w_beat_addr;

  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;

  logic              r_rd_vld;
  arb_owner          r_rd_owner;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_dma_rdata;
  logic              r_dma_rvalid;

  // --------------------------------------------------------------------------
  // Slot decode. A CPU slot always wins; a dual-strobe access is a write.
  // --------------------------------------------------------------------------
  assign w_cpu_slot = clk_en & (cpu_read_en | cpu_write_en);
  assign w_cpu_rd   = w_cpu_slot & cpu_read_en & ~cpu_write_en;

  // A burst is accepted from IDLE; its first beat can go out immediately.
  // Beats are masked while reset is held so outputs sit at reset values.
  assign w_load = (r_state == ARB_IDLE) & dma_req;
  assign w_beat = ((r_state == ARB_BURST) | w_load) & ~w_cpu_slot & reset_n;

  // Direction is taken live in the start cycle, then from the latched copy.
  assign w_dir    = (r_state == ARB_IDLE) ? dma_write : r_dir;
  assign w_dma_rd = w_beat & ~w_dir;

  // --------------------------------------------------------------------------
  // Beat address / last-beat source
  // --------------------------------------------------------------------------
`ifdef MEM_ARBITER_BURST_EN
  mem_arbiter_burst #(
    .ADDR_W (ADDR_W)
  ) u_burst (
    .clk     (clk),
    .reset_n (reset_n),
    .i_load  (w_load),
    .i_addr  (dma_addr),
    .i_len   (dma_len),
    .i_beat  (w_beat),
    .o_addr  (w_beat_addr),
    .o_last  (w_last)
  );
`else
  logic [ADDR_W-1:0] r_single_addr;
  logic              w_unused_len;

  // Single-beat mode: the address is only held for the case where a CPU
  // slot pushes the beat out of the start cycle.
  assign w_unused_len = ^dma_len;
  assign w_beat_addr  = (r_state == ARB_IDLE) ? dma_addr : r_single_addr;
  assign w_last       = 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_single_addr <= '0;
    end else if (w_load) begin
      r_single_addr <= dma_addr;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Arbiter FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ARB_IDLE;
      r_dir   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_dir <= dma_write;
      end
    end
  end

  // A single-beat request issued in its start cycle never leaves IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ARB_IDLE: begin
        if (w_load && !(w_beat && w_last)) begin
          w_state_nxt = ARB_BURST;
        end
      end
      ARB_BURST: begin
        if (w_beat && w_last) begin
          w_state_nxt = ARB_IDLE;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  assign dma_ack  = w_beat;
  assign dma_done = w_beat & w_last;

  // --------------------------------------------------------------------------
  // RAM control mux. With no access the address and data hold their last
  // driven values so the macro inputs do not toggle needlessly.
  // --------------------------------------------------------------------------
  always_comb begin
    ram_addr  = r_ram_addr;
    ram_we    = 1'b0;
    ram_wdata = r_ram_wdata;
    if (!reset_n) begin
      ram_addr  = '0;
      ram_wdata = '0;
    end else if (w_cpu_slot) begin
      ram_addr  = cpu_addr;
      ram_we    = cpu_write_en;
      ram_wdata = cpu_write_data;
    end else if (w_beat) begin
      ram_addr  = w_beat_addr;
      ram_we    = w_dir;
      ram_wdata = dma_write_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
    end else begin
      r_ram_addr  <= ram_addr;
      r_ram_wdata <= ram_wdata;
    end
  end

  // --------------------------------------------------------------------------
  // Read return: owner tag and valid follow the access by one cycle, when
  // the RAM presents its data; the result is registered one cycle later.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_vld     <= 1'b0;
      r_rd_owner   <= OWNER_CPU;
      r_cpu_rdata  <= '0;
      r_dma_rdata  <= '0;
      r_dma_rvalid <= 1'b0;
    end else begin
      r_rd_vld     <= w_cpu_rd | w_dma_rd;
      r_rd_owner   <= w_cpu_rd ? OWNER_CPU : OWNER_DMA;
      r_dma_rvalid <= 1'b0;
      if (r_rd_vld) begin
        if (r_rd_owner == OWNER_CPU) begin
          r_cpu_rdata <= ram_rdata;
        end else begin
          r_dma_rdata  <= ram_rdata;
          r_dma_rvalid <= 1'b1;
        end
      end
    end
  end

  assign cpu_read_data  = r_cpu_rdata;
  assign dma_read_data  = r_dma_rdata;
  assign dma_read_valid = r_dma_rvalid;

endmodule : mem_arbiter

`default_nettype wire
